// File: rtl/anim_pkg.sv
// Shared types and sequence lengths for the character animation controller.
// The state encoding and frame counts are the contract with the sprite reader.
package anim_pkg;

  typedef enum logic [7:0] {
    ST_STAND   = 8'd0,
    ST_ATTACK  = 8'd1,
    ST_MOVEL   = 8'd2,
    ST_MOVER   = 8'd3,
    ST_DEFENSE = 8'd4,
    ST_HURT    = 8'd5
  } char_state_t;

  localparam logic [7:0] STAND_FRAMES    = 8'd9;
  localparam logic [7:0] FORWARD_FRAMES  = 8'd10;
  localparam logic [7:0] BACKWARD_FRAMES = 8'd9;
  localparam logic [7:0] ATTACK_FRAMES   = 8'd6;
  localparam logic [7:0] DEFENSE_FRAMES  = 8'd1;
  localparam logic [7:0] HURT_FRAMES     = 8'd5;

  // Number of frames in the sequence shown for a given state.
  function automatic logic [7:0] frames_of(char_state_t s);
    case (s)
      ST_ATTACK:  return ATTACK_FRAMES;
      ST_MOVEL:   return FORWARD_FRAMES;
      ST_MOVER:   return BACKWARD_FRAMES;
      ST_DEFENSE: return DEFENSE_FRAMES;
      ST_HURT:    return HURT_FRAMES;
      default:    return STAND_FRAMES;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and turns each
// rising edge into a single-cycle tick, three Clk edges after the rise.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  // sync_pipe[0..1] is the metastability pair, sync_pipe[2] the edge-detect delay.
  logic [2:0] sync_pipe;

  // Synchronizer shift register and registered rising-edge pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_pipe <= '0;
      tick      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], frame_clk};
      tick      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

endmodule

// File: rtl/character_anim_ctrl.sv
// Turns player/game commands into a sprite state, frame index and x position,
// stepping only on the synchronized frame tick (hit capture excepted).
module character_anim_ctrl
  import anim_pkg::*;
#(
  parameter int unsigned TICKS_PER_FRAME = 4,
  parameter int unsigned X_INIT          = 400,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 539,
  parameter int unsigned STEP            = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       attack_req,
  input  logic       defense_req,
  input  logic       hit,
  output logic [7:0] character_state,
  output logic [7:0] frame_num,
  output logic [9:0] pos_x,
  output logic       busy
);

  localparam logic [3:0] TPF_LAST = 4'(TICKS_PER_FRAME - 1);

  logic        tick;
  logic        hit_pend;
  char_state_t state_q, nxt_state, choice;
  logic [3:0]  tick_cnt, nxt_cnt;
  logic [7:0]  nxt_frame, last_frame;
  logic [9:0]  nxt_x;
  logic [10:0] x_ext, x_inc;
  logic        restart, seq_done;

  frame_tick_sync u_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign character_state = state_q;

  // Hit is held until the next tick; a hit on the tick cycle itself stays pending.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  hit_pend <= 1'b0;
    else if (tick) hit_pend <= hit;
    else if (hit)  hit_pend <= 1'b1;
  end

  // Command priority below hurt; conflicting move requests mean stand.
  always_comb begin
    choice = ST_STAND;
    if (attack_req)                     choice = ST_ATTACK;
    else if (defense_req)               choice = ST_DEFENSE;
    else if (move_left && !move_right)  choice = ST_MOVEL;
    else if (move_right && !move_left)  choice = ST_MOVER;
  end

  // Next state, frame and tick counter; one-shots only yield at end of sequence.
  always_comb begin
    nxt_state  = state_q;
    restart    = 1'b0;
    last_frame = frames_of(state_q) - 8'd1;
    seq_done   = (tick_cnt == TPF_LAST) && (frame_num == last_frame);
    case (state_q)
      ST_HURT: begin
        if (hit_pend)      restart = 1'b1;
        else if (seq_done) begin nxt_state = choice; restart = 1'b1; end
      end
      ST_ATTACK: begin
        if (hit_pend)      begin nxt_state = ST_HURT; restart = 1'b1; end
        else if (seq_done) begin nxt_state = choice;  restart = 1'b1; end
      end
      default: begin
        nxt_state = hit_pend ? ST_HURT : choice;
        restart   = (nxt_state != state_q);
      end
    endcase

    nxt_cnt   = tick_cnt + 4'd1;
    nxt_frame = frame_num;
    if (restart) begin
      nxt_cnt   = '0;
      nxt_frame = '0;
    end else if (tick_cnt == TPF_LAST) begin
      nxt_cnt   = '0;
      nxt_frame = (frame_num == last_frame) ? 8'd0 : frame_num + 8'd1;
    end
  end

  // Position step for the state being entered, clamped in 11 bits.
  always_comb begin
    x_ext = {1'b0, pos_x};
    x_inc = x_ext + 11'(STEP);
    nxt_x = pos_x;
    if (nxt_state == ST_MOVEL) begin
      if (x_ext < 11'(X_MIN) + 11'(STEP)) nxt_x = 10'(X_MIN);
      else                                nxt_x = pos_x - 10'(STEP);
    end else if (nxt_state == ST_MOVER) begin
      if (x_inc > 11'(X_MAX)) nxt_x = 10'(X_MAX);
      else                    nxt_x = x_inc[9:0];
    end
  end

  // Registered outputs, all updated on the cycle after tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_STAND;
      frame_num <= '0;
      tick_cnt  <= '0;
      pos_x     <= 10'(X_INIT);
      busy      <= 1'b0;
    end else if (tick) begin
      state_q   <= nxt_state;
      frame_num <= nxt_frame;
      tick_cnt  <= nxt_cnt;
      pos_x     <= nxt_x;
      busy      <= (nxt_state == ST_ATTACK) || (nxt_state == ST_HURT);
    end
  end

endmodule
